// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator for a VGA DAC.
//
// Purpose:
//   Sweeps a horizontal and a vertical counter across the full raster,
//   including the porches and the sync pulses. The visible coordinate
//   (o_x, o_y) goes out to the frame ROMs. The ROM returns the pixel colour
//   combinationally on i_rgb. On every enabled cycle one register stage
//   captures colour, syncs, blank and the frame-start marker together, so
//   all DAC-side outputs stay mutually aligned one enabled cycle behind the
//   counters.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_pix_en       pixel-clock enable; all state advances only when 1
//   o_x, o_y       visible column/row (0 outside the visible area), combinational
//   i_rgb          {R,G,B} from the frame ROM for the current o_x/o_y
//   o_vga_r/g/b    registered DAC colour (0 while blanked)
//   o_vga_hs/vs    registered active-low syncs
//   o_vga_blank_n  registered, 1 during the visible area
//   o_vga_sync_n   constant 0 (sync-on-green unused)
//   o_frame_start  one-clock pulse aligned with output pixel (0,0)
//   o_frame_cnt    registered count of completed frames, wraps 255->0
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_en,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  input  logic [23:0] i_rgb,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_blank_n,
  output logic        o_vga_sync_n,
  output logic        o_frame_start,
  output logic [7:0]  o_frame_cnt
);

  // Raster geometry, all expressed in the 10-bit counter domain.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_W    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_W   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_S_W = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E_W = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_W    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_W   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_S_W = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E_W = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic [23:0] rgb_r;
  logic        hs_r;
  logic        vs_r;
  logic        blank_n_r;
  logic        frame_start_r;
  logic [7:0]  frame_cnt_r;

  logic        h_vis_s;
  logic        v_vis_s;
  logic        visible_s;
  logic        h_last_s;
  logic        v_last_s;
  logic        hs_raw_s;
  logic        vs_raw_s;
  logic        at_origin_s;
  logic [9:0]  x_s;
  logic [8:0]  y_s;

  // Decode the counter position: visibility, wrap points, raw syncs, coordinates.
  always_comb begin
    h_vis_s     = (h_cnt_r < H_ACT_W);
    v_vis_s     = (v_cnt_r < V_ACT_W);
    visible_s   = h_vis_s && v_vis_s;
    h_last_s    = (h_cnt_r == H_LAST_W);
    v_last_s    = (v_cnt_r == V_LAST_W);
    hs_raw_s    = !((h_cnt_r >= H_SYNC_S_W) && (h_cnt_r < H_SYNC_E_W));
    vs_raw_s    = !((v_cnt_r >= V_SYNC_S_W) && (v_cnt_r < V_SYNC_E_W));
    at_origin_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    x_s         = 10'd0;
    y_s         = 9'd0;
    if (h_vis_s) begin
      x_s = h_cnt_r;
    end else begin
      x_s = 10'd0;
    end
    // The visible row range fits in 9 bits, so dropping bit 9 loses nothing.
    if (v_vis_s) begin
      y_s = v_cnt_r[8:0];
    end else begin
      y_s = 9'd0;
    end
  end

  // Raster counters and the single aligned output register stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_r       <= 10'd0;
      v_cnt_r       <= 10'd0;
      rgb_r         <= 24'h000000;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b0;
      frame_start_r <= 1'b0;
      frame_cnt_r   <= 8'd0;
    end else if (i_pix_en) begin
      rgb_r         <= visible_s ? i_rgb : 24'h000000;
      hs_r          <= hs_raw_s;
      vs_r          <= vs_raw_s;
      blank_n_r     <= visible_s;
      frame_start_r <= at_origin_s;
      if (h_last_s) begin
        h_cnt_r <= 10'd0;
        if (v_last_s) begin
          v_cnt_r     <= 10'd0;
          frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
          v_cnt_r <= v_cnt_r + 10'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end else begin
      // Everything holds, except the frame marker, which must stay a
      // single-clock pulse even when the enable is sparse.
      frame_start_r <= 1'b0;
    end
  end

  assign o_x           = x_s;
  assign o_y           = y_s;
  assign o_vga_r       = rgb_r[23:16];
  assign o_vga_g       = rgb_r[15:8];
  assign o_vga_b       = rgb_r[7:0];
  assign o_vga_hs      = hs_r;
  assign o_vga_vs      = vs_r;
  assign o_vga_blank_n = blank_n_r;
  assign o_vga_sync_n  = 1'b0;
  assign o_frame_start = frame_start_r;
  assign o_frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen, using a reduced raster so that 256 full
// frames fit in a short run. The reference model tracks a linear raster
// position and derives column/row with division and modulo.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [23:0] i_rgb;
  logic [23:0] rgb_key;
  logic [7:0]  o_vga_r, o_vga_g, o_vga_b;
  logic        o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n, o_frame_start;
  logic [7:0]  o_frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          pos;
  logic [23:0] e_rgb;
  bit          e_hs, e_vs, e_bl, e_fs;
  int          e_fc;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x(o_x), .o_y(o_y), .i_rgb(i_rgb),
    .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
    .o_vga_hs(o_vga_hs), .o_vga_vs(o_vga_vs),
    .o_vga_blank_n(o_vga_blank_n), .o_vga_sync_n(o_vga_sync_n),
    .o_frame_start(o_frame_start), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural frame ROM: colour is a function of the presented coordinate.
  assign i_rgb = {o_x[7:0], o_y[7:0], 8'hA5} ^ rgb_key;

  function automatic logic [23:0] rom_val(input int h, input int v);
    logic [7:0] hb;
    logic [7:0] vb;
    hb = 8'(h);
    vb = 8'(v);
    return {hb, vb, 8'hA5} ^ rgb_key;
  endfunction

  // Drive one clock from the negedge, advance the model, return at the next negedge.
  task automatic tick(input bit r, input bit en);
    int h;
    int v;
    bit vis;
    rst    = r;
    pix_en = en;
    @(posedge clk);
    if (r) begin
      pos = 0; e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0; e_fc = 0;
    end else if (en) begin
      h     = pos % HT;
      v     = pos / HT;
      vis   = (h < HA) && (v < VA);
      e_rgb = vis ? rom_val(h, v) : 24'h0;
      e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      e_bl  = vis;
      e_fs  = (pos == 0);
      if (pos == FT - 1) e_fc = (e_fc + 1) % 256;
      pos = (pos + 1) % FT;
    end else begin
      e_fs = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, k[0]);
      n_chk += 9;
      if ({o_vga_r, o_vga_g, o_vga_b} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h exp 000000", {o_vga_r, o_vga_g, o_vga_b}); end
      if (o_vga_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs got %b exp 1", o_vga_hs); end
      if (o_vga_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs got %b exp 1", o_vga_vs); end
      if (o_vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL reset_blank got %b exp 0", o_vga_blank_n); end
      if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", o_frame_start); end
      if (o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_fc got %0d exp 0", o_frame_cnt); end
      if (o_x !== 10'd0) begin n_fail++; $display("FAIL reset_x got %0d exp 0", o_x); end
      if (o_y !== 9'd0) begin n_fail++; $display("FAIL reset_y got %0d exp 0", o_y); end
      if (o_vga_sync_n !== 1'b0) begin n_fail++; $display("FAIL reset_sync_n got %b exp 0", o_vga_sync_n); end
    end
  endtask

  // Stream nframes of enabled cycles from a freshly reset raster.
  // mode 0: enable always on, mode 1: 1,0,1,0 toggle, mode 2: random enable.
  task automatic test_stream(input int nframes, input int mode, input string tag);
    int en_cnt = 0, cyc = 0, bl_cnt = 0, hs_low = 0, vs_low = 0, fs_cnt = 0, run = 0;
    bit en;
    int ex, ey;
    logic [36:0] prev, cur;
    rgb_key = 24'($urandom);
    tick(1'b1, 1'b0);
    prev = {o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs, o_vga_blank_n, o_frame_cnt, o_frame_start, 2'b00};
    while (en_cnt < nframes * FT) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      cyc++;
      tick(1'b0, en);
      ex = ((pos % HT) < HA) ? (pos % HT) : 0;
      ey = ((pos / HT) < VA) ? (pos / HT) : 0;
      n_chk += 7;
      if ({o_vga_r, o_vga_g, o_vga_b} !== e_rgb) begin n_fail++; $display("FAIL %s rgb pos=%0d got %h exp %h", tag, pos, {o_vga_r, o_vga_g, o_vga_b}, e_rgb); end
      if (o_vga_hs !== e_hs || o_vga_vs !== e_vs) begin n_fail++; $display("FAIL %s sync pos=%0d got %b%b exp %b%b", tag, pos, o_vga_hs, o_vga_vs, e_hs, e_vs); end
      if (o_vga_blank_n !== e_bl) begin n_fail++; $display("FAIL %s blank pos=%0d got %b exp %b", tag, pos, o_vga_blank_n, e_bl); end
      if (o_frame_start !== e_fs) begin n_fail++; $display("FAIL %s frame_start pos=%0d got %b exp %b", tag, pos, o_frame_start, e_fs); end
      if (o_frame_cnt !== 8'(e_fc)) begin n_fail++; $display("FAIL %s frame_cnt got %0d exp %0d", tag, o_frame_cnt, e_fc); end
      if (o_x !== 10'(ex) || o_y !== 9'(ey)) begin n_fail++; $display("FAIL %s xy pos=%0d got %0d,%0d exp %0d,%0d", tag, pos, o_x, o_y, ex, ey); end
      if (o_vga_sync_n !== 1'b0) begin n_fail++; $display("FAIL %s sync_n got %b exp 0", tag, o_vga_sync_n); end
      cur = {o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs, o_vga_blank_n, o_frame_cnt, 1'b0, 2'b00};
      if (!en) begin
        n_chk++;
        if (cur !== prev) begin n_fail++; $display("FAIL %s hold got %h exp %h", tag, cur, prev); end
      end else begin
        en_cnt++;
        if (o_vga_blank_n) bl_cnt++;
        if (!o_vga_vs) vs_low++;
        if (!o_vga_hs) begin hs_low++; run++; end
        else if (run > 0) begin
          n_chk++;
          if (run != HS) begin n_fail++; $display("FAIL %s hs_width got %0d exp %0d", tag, run, HS); end
          run = 0;
        end
      end
      if (o_frame_start) begin
        fs_cnt++;
        n_chk++;
        if (o_vga_blank_n !== 1'b1) begin n_fail++; $display("FAIL %s fs_blank got %b exp 1", tag, o_vga_blank_n); end
      end
      prev = cur;
    end
    n_chk += 5;
    if (bl_cnt != HA * VA * nframes) begin n_fail++; $display("FAIL %s visible_count got %0d exp %0d", tag, bl_cnt, HA * VA * nframes); end
    if (hs_low != HS * VT * nframes) begin n_fail++; $display("FAIL %s hs_low_count got %0d exp %0d", tag, hs_low, HS * VT * nframes); end
    if (vs_low != VS * HT * nframes) begin n_fail++; $display("FAIL %s vs_low_count got %0d exp %0d", tag, vs_low, VS * HT * nframes); end
    if (fs_cnt != nframes) begin n_fail++; $display("FAIL %s fs_pulses got %0d exp %0d", tag, fs_cnt, nframes); end
    if (o_frame_cnt !== 8'(nframes % 256)) begin n_fail++; $display("FAIL %s final_frame_cnt got %0d exp %0d", tag, o_frame_cnt, nframes % 256); end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 1'b0);
    // Walk to column 5, row 3, then finish a frame so frame_cnt is non-zero.
    for (int k = 0; k < FT + 3 * HT + 5; k++) tick(1'b0, 1'b1);
    n_chk++;
    if (o_x !== 10'd5 || o_y !== 9'd3) begin n_fail++; $display("FAIL mid_pos got %0d,%0d exp 5,3", o_x, o_y); end
    tick(1'b1, 1'b1);
    n_chk += 4;
    if ({o_vga_r, o_vga_g, o_vga_b} !== 24'h0 || o_vga_blank_n !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got %h/%b exp 000000/0", {o_vga_r, o_vga_g, o_vga_b}, o_vga_blank_n); end
    if (o_vga_hs !== 1'b1 || o_vga_vs !== 1'b1) begin n_fail++; $display("FAIL mid_rst_sync got %b%b exp 11", o_vga_hs, o_vga_vs); end
    if (o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_fc got %0d exp 0", o_frame_cnt); end
    if (o_x !== 10'd0 || o_y !== 9'd0) begin n_fail++; $display("FAIL mid_rst_xy got %0d,%0d exp 0,0", o_x, o_y); end
    tick(1'b0, 1'b0);
    n_chk++;
    if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_idle_fs got %b exp 0", o_frame_start); end
    tick(1'b0, 1'b1);
    n_chk += 3;
    if (o_frame_start !== 1'b1) begin n_fail++; $display("FAIL mid_fs got %b exp 1", o_frame_start); end
    if ({o_vga_r, o_vga_g, o_vga_b} !== rom_val(0, 0)) begin n_fail++; $display("FAIL mid_rgb00 got %h exp %h", {o_vga_r, o_vga_g, o_vga_b}, rom_val(0, 0)); end
    if (o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_fc got %0d exp 0", o_frame_cnt); end
    tick(1'b0, 1'b1);
    n_chk++;
    if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_fs_end got %b exp 0", o_frame_start); end
  endtask

  initial begin
    rst     = 1'b1;
    pix_en  = 1'b0;
    rgb_key = 24'h0;
    @(negedge clk);
    test_reset();
    test_stream(1, 0, "full_rate");
    test_stream(1, 1, "toggle_en");
    test_mid_reset();
    test_stream(256, 2, "frames256");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48 (horizontal porch/sync widths in pixels; line total 800).
REQ-003 SHALL have parameter V_ACTIVE, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33 (vertical widths in lines; frame total 525).
REQ-004 i_clk  input  1  system clock, single clock domain; all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_pix_en  input  1  pixel-clock enable; counters and output registers advance only on cycles where it is 1.
REQ-007 o_x  output  10  current visible column sent to frame ROMs.
REQ-008 o_y  output  9  current visible row sent to frame ROMs.
REQ-009 i_rgb  input  24  pixel colour {R,G,B} returned combinationally by the frame ROM for o_x/o_y in the same cycle.
REQ-010 o_vga_r, o_vga_g, o_vga_b  output  8 each  registered DAC colour.
REQ-011 o_vga_hs, o_vga_vs  output  1 each  registered sync, active-low.
REQ-012 o_vga_blank_n  output  1  registered, 1 during visible area.
REQ-013 o_vga_sync_n  output  1  tied constant 0.
REQ-014 o_frame_start  output  1  registered one-enable-cycle pulse aligned with output pixel (0,0).
REQ-015 o_frame_cnt  output  8  registered count of completed frames.

Function
REQ-016 h_cnt SHALL count 0..799 and wrap to 0, incrementing only when i_pix_en=1.
REQ-017 v_cnt SHALL count 0..524, incrementing only on the enabled cycle where h_cnt wraps 799->0, and wrap 524->0 at the same point.
REQ-018 Visible SHALL be h_cnt<640 AND v_cnt<480.
REQ-019 o_x SHALL equal h_cnt when h_cnt<640, else 0; o_y SHALL equal v_cnt when v_cnt<480, else 0; both combinational from counters.
REQ-020 hsync_raw SHALL be 0 for h_cnt in 656..751, else 1; vsync_raw SHALL be 0 for v_cnt in 490..491, else 1.
REQ-021 On each enabled cycle the output registers SHALL load: RGB = i_rgb if visible else 24'h000000; hs/vs = raw syncs; blank_n = visible.
REQ-022 Latency SHALL be exactly one enabled cycle from counter value to the matching RGB/sync/blank outputs, so all outputs stay mutually aligned.
REQ-023 On cycles with i_pix_en=0 all counters and registered outputs SHALL hold their values.
REQ-024 o_frame_start SHALL be 1 for exactly the enabled cycle after counters were at (0,0), and 0 otherwise, including held at 0 through disabled cycles.
REQ-025 o_frame_cnt SHALL increment by 1 on the enabled cycle where v_cnt wraps 524->0 and h_cnt wraps 799->0, wrapping 255->0.
REQ-026 Derived widths SHALL be 10-bit for h_cnt and v_cnt; no intermediate truncation of o_y beyond 9 bits (max 479).

Reset
REQ-027 When i_rst=1 at a clock edge: h_cnt=0, v_cnt=0, RGB=0, hs=1, vs=1, blank_n=0, frame_start=0, frame_cnt=0, regardless of i_pix_en.
REQ-028 Reset asserted mid-line or mid-frame SHALL abort the frame; the first enabled cycle after release presents o_x=0, o_y=0, and the next enabled cycle raises o_frame_start.
REQ-029 o_vga_sync_n SHALL be 0 during and after reset.

Verification
REQ-030 Reset, then i_pix_en=1 constantly for 800*525 cycles -> hs low 96 cycles per line starting one cycle after h_cnt=656; vs low for 2 lines; exactly 640*480 cycles with blank_n=1.
REQ-031 i_rgb driven as {o_x[7:0], o_y[7:0], 8'hA5} -> at blank_n=1 the output RGB equals the value for the previous cycle's o_x/o_y; at blank_n=0 RGB=0.
REQ-032 i_pix_en toggling 1,0,1,0 (50 MHz board clock) -> identical output sequence to REQ-030 on enabled cycles; all outputs stable on disabled cycles.
REQ-033 Run 256 frames -> o_frame_start pulses 256 times, o_frame_cnt returns to 0; pulse coincides with first blank_n=1 cycle of each frame.
REQ-034 Assert i_rst for 1 cycle at h_cnt=300, v_cnt=200 -> next cycle outputs at reset values; after release o_x=0,o_y=0, frame_start pulses on the following enabled cycle, frame_cnt=0.
REQ-035 Hold i_rst=1 with i_pix_en=0 -> reset still takes effect (REQ-027 values).
